// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request found scanning
// ptr_i, ptr_i+1, ... wrapping modulo N.
module rr_priority_picker
    import mem_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = id_width(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [N-1:0]    gnt_onehot_o,
    output logic [ID_W-1:0] gnt_id_o,
    output logic            any_o
);

    int               idx_int_s;
    logic [ID_W-1:0]  idx_s;
    logic             found_s;

    // Scan the requests starting at the pointer and keep the first hit.
    always_comb begin
        gnt_onehot_o = '0;
        gnt_id_o     = '0;
        found_s      = 1'b0;
        idx_int_s    = 0;
        idx_s        = '0;
        for (int i = 0; i < N; i++) begin
            idx_int_s = (int'(ptr_i) + i) % N;
            idx_s     = ID_W'(idx_int_s);
            if (!found_s && req_i[idx_s]) begin
                found_s             = 1'b1;
                gnt_id_o            = idx_s;
                gnt_onehot_o[idx_s] = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between N_REQ
// requesters. One transaction every three cycles: IDLE picks and latches,
// ACCESS drives the memory port, RESP presents the registered response.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = ARB_ADDR_W,
    parameter int DATA_W    = ARB_DATA_W,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]       resp_rdata,
    output logic                    resp_err,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata
);

    localparam int ID_W = id_width(N_REQ);

    arb_state_t         state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               err_q, err_d;
    logic [N_REQ-1:0]   req_ready_q, req_ready_d;
    logic [N_REQ-1:0]   resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]  resp_rdata_q, resp_rdata_d;
    logic               resp_err_q, resp_err_d;

    logic [N_REQ-1:0]   pick_onehot_s;
    logic [ID_W-1:0]    pick_id_s;
    logic               pick_any_s;
    logic [ADDR_W-1:0]  sel_addr_s;
    logic [DATA_W-1:0]  sel_wdata_s;
    logic               sel_we_s;
    logic [N_REQ-1:0]   id_onehot_s;
    logic               in_access_s;

    rr_priority_picker #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_picker (
        .req_i        (req_valid),
        .ptr_i        (rr_ptr_q),
        .gnt_onehot_o (pick_onehot_s),
        .gnt_id_o     (pick_id_s),
        .any_o        (pick_any_s)
    );

    // AND-OR mux of the winning requester's fields.
    always_comb begin
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        sel_we_s    = |(pick_onehot_s & req_we);
        for (int i = 0; i < N_REQ; i++) begin
            sel_addr_s  = sel_addr_s  | ({ADDR_W{pick_onehot_s[i]}} & req_addr[i*ADDR_W +: ADDR_W]);
            sel_wdata_s = sel_wdata_s | ({DATA_W{pick_onehot_s[i]}} & req_wdata[i*DATA_W +: DATA_W]);
        end
    end

    assign id_onehot_s = {{(N_REQ-1){1'b0}}, 1'b1} << id_q;
    assign in_access_s = (state_q == ARB_ACCESS);

    // Next-state, latched-transaction and registered-output logic.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        req_ready_d  = '0;
        resp_valid_d = '0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any_s) begin
                    state_d     = ARB_ACCESS;
                    id_d        = pick_id_s;
                    we_d        = sel_we_s;
                    addr_d      = sel_addr_s;
                    wdata_d     = sel_wdata_s;
                    err_d       = (sel_addr_s >= ADDR_W'(MEM_DEPTH));
                    req_ready_d = pick_onehot_s;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_ACCESS: begin
                state_d      = ARB_RESP;
                rr_ptr_d     = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
                resp_valid_d = id_onehot_s;
                resp_rdata_d = (we_q | err_q) ? '0 : mem_rdata;
                resp_err_d   = err_q;
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            req_ready_q  <= '0;
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    // The memory writes on the negedge, so rst gates the enable directly:
    // a reset raised during ACCESS must not let that write land.
    assign mem_we    = in_access_s & we_q & ~err_q & ~rst;
    assign mem_addr  = in_access_s ? addr_q  : '0;
    assign mem_wdata = in_access_s ? wdata_q : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural memory and a
// queue-based scoreboard checked by an independent monitor.
module tb_data_mem_arbiter;

    localparam int N     = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid, req_we, req_ready, resp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   resp_rdata, mem_wdata, mem_rdata;
    logic            resp_err, mem_we;
    logic [AW-1:0]   mem_addr;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   gnt_q[$];
    int   resp_cyc_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int we_seen = 0;
    int last_ready_cyc = 0;
    int last_resp_cyc = 0;

    // Memory: unwritten words read back a known pattern A000_0000 | addr.
    logic [31:0]    mem [0:DEPTH-1];
    logic [DEPTH-1:0] written = '0;

    function automatic logic [31:0] mem_peek(input int a);
        if (a >= DEPTH) return 32'h0;
        if (written[a]) return mem[a];
        return 32'hA000_0000 | 32'(a);
    endfunction

    always @(negedge clk) begin
        if (mem_we === 1'b1 && mem_addr < 32'(DEPTH)) begin
            mem[mem_addr[9:0]]     <= mem_wdata;
            written[mem_addr[9:0]] <= 1'b1;
        end
    end

    assign mem_rdata = mem_peek(int'(mem_addr));

    data_mem_arbiter #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every ready / response pulse against the queues.
    always @(negedge clk) begin
        exp_t e;
        int   g;
        if (mem_we === 1'b1) we_seen++;
        if (req_ready !== '0) begin
            last_ready_cyc = cyc;
            if (gnt_q.size() == 0) begin
                check("unexpected_ready", 32'(req_ready), 32'h0);
            end else begin
                g = gnt_q.pop_front();
                check("ready_onehot", 32'(req_ready), 32'h1 << g);
            end
        end
        if (resp_valid !== '0) begin
            last_resp_cyc = cyc;
            resp_cyc_q.push_back(cyc);
            if (sb_q.size() == 0) begin
                check("unexpected_resp", 32'(resp_valid), 32'h0);
            end else begin
                e = sb_q.pop_front();
                check("resp_onehot", 32'(resp_valid), 32'h1 << e.id);
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", 32'(resp_err), 32'(e.err));
            end
        end
    end

    task automatic expect_txn(input int id, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.id = id; e.rdata = rdata; e.err = err;
        sb_q.push_back(e);
        gnt_q.push_back(id);
    endtask

    task automatic set_req(input int id, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        req_we[id]             = we;
        req_addr[id*AW +: AW]  = addr;
        req_wdata[id*DW +: DW] = wdata;
        req_valid[id]          = 1'b1;
    endtask

    // Drive until all expected responses are seen; drop valid after ready
    // except for requesters in hold, which keep requesting until the end.
    task automatic run(input logic [N-1:0] hold, input int budget);
        logic [N-1:0] rdy;
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk); #1;
            req_valid = req_valid & ~(rdy & ~hold);
            n++;
        end
        req_valid = req_valid & ~hold;
        check("drain_resp", 32'(sb_q.size()), 32'h0);
        check("drain_gnt", 32'(gnt_q.size()), 32'h0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
        check({tag, "_resp_rdata"}, resp_rdata, 32'h0);
        check({tag, "_resp_err"}, 32'(resp_err), 32'h0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'h0);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int we0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        rst       = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: write then read back, with latency checks
        expect_txn(0, 32'h0, 1'b0);
        set_req(0, 1'b1, 32'd5, 32'hDEAD_BEEF);
        c0 = cyc;
        run('0, 20);
        check("t1_ready_lat", 32'(last_ready_cyc - c0), 32'd1);
        check("t1_resp_lat", 32'(last_resp_cyc - c0), 32'd2);
        check("t1_mem5", mem_peek(5), 32'hDEAD_BEEF);
        expect_txn(0, 32'hDEAD_BEEF, 1'b0);
        set_req(0, 1'b0, 32'd5, 32'h0);
        c0 = cyc;
        run('0, 20);
        check("t1_rd_resp_lat", 32'(last_resp_cyc - c0), 32'd2);

        // 6: requester drops valid during ACCESS
        expect_txn(0, 32'hA000_000A, 1'b0);
        set_req(0, 1'b0, 32'd10, 32'h0);
        c0 = cyc;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        run('0, 20);
        check("t6_resp_lat", 32'(last_resp_cyc - c0), 32'd2);

        // 4: out-of-range write
        we0 = we_seen;
        expect_txn(2, 32'h0, 1'b1);
        set_req(2, 1'b1, 32'd1024, 32'h1);
        run('0, 20);
        check("t4_no_mem_we", 32'(we_seen - we0), 32'h0);
        check("t4_mem0", mem_peek(0), 32'hA000_0000);

        // 5: reset during ACCESS of a write to address 7
        we0 = we_seen;
        gnt_q.push_back(0);
        set_req(0, 1'b1, 32'd7, 32'h0000_0077);
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        @(negedge clk);
        check_outputs_zero("t5_after_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("t5_mem7", mem_peek(7), 32'hA000_0007);
        check("t5_no_mem_we", 32'(we_seen - we0), 32'h0);
        check("t5_gnt_seen", 32'(gnt_q.size()), 32'h0);

        // 2: all four valid after reset -> 0,1,2,3 every three cycles
        resp_cyc_q.delete();
        for (int i = 0; i < N; i++) begin
            expect_txn(i, 32'hA000_0064 + 32'(i), 1'b0);
            set_req(i, 1'b0, 32'd100 + 32'(i), 32'h0);
        end
        run('0, 40);
        check("t2_resp_count", 32'(resp_cyc_q.size()), 32'd4);
        for (int k = 1; k < resp_cyc_q.size(); k++) begin
            check("t2_resp_spacing", 32'(resp_cyc_q[k] - resp_cyc_q[k-1]), 32'd3);
        end
        // Pointer wrapped back to 0: requesters 0 and 3 -> 0 first, then 3
        expect_txn(0, 32'hA000_0068, 1'b0);
        expect_txn(3, 32'hA000_0069, 1'b0);
        set_req(3, 1'b0, 32'd105, 32'h0);
        set_req(0, 1'b0, 32'd104, 32'h0);
        run('0, 20);

        // 3: requester 1 alone moves pointer to 2; then 1 and 3 held -> 3,1,3,1
        expect_txn(1, 32'hA000_0014, 1'b0);
        set_req(1, 1'b0, 32'd20, 32'h0);
        run('0, 20);
        expect_txn(3, 32'hA000_001E, 1'b0);
        expect_txn(1, 32'hA000_0014, 1'b0);
        expect_txn(3, 32'hA000_001E, 1'b0);
        expect_txn(1, 32'hA000_0014, 1'b0);
        set_req(1, 1'b0, 32'd20, 32'h0);
        set_req(3, 1'b0, 32'd30, 32'h0);
        run(4'b1010, 60);
        repeat (4) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
